prince_sbox_layer_ctrl: RTL and testbench

//  Sequences one 3-share masked PRINCE S-box instance (SB_TSM_d2) over a 64-bit shared state.

---
 rtl/prince_sbox_layer_ctrl_if.sv | 37 +++
 rtl/prince_sbox_layer_ctrl.sv | 144 ++++++++++++++
 tb/tb_prince_sbox_layer_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/prince_sbox_layer_ctrl_if.sv
// Bus between the PRINCE round controller, the PRNG and one masked S-box instance, as seen by
// prince_sbox_layer_ctrl (slave) and by whoever drives it (master).
interface prince_sbox_layer_ctrl_if #(
    parameter int unsigned RND_W = 54
);
    logic             start;
    logic [63:0]      in_sh0;
    logic [63:0]      in_sh1;
    logic [63:0]      in_sh2;
    logic             busy;
    logic             done;
    logic [63:0]      out_sh0;
    logic [63:0]      out_sh1;
    logic [63:0]      out_sh2;
    logic [RND_W-1:0] rnd;
    logic             rnd_valid;
    logic             rnd_req;
    logic [3:0]       sb_in_sh0;
    logic [3:0]       sb_in_sh1;
    logic [3:0]       sb_in_sh2;
    logic [RND_W-1:0] sb_rnd;
    logic [3:0]       sb_out_sh0;
    logic [3:0]       sb_out_sh1;
    logic [3:0]       sb_out_sh2;

    modport slave (
        input  start, in_sh0, in_sh1, in_sh2, rnd, rnd_valid, sb_out_sh0, sb_out_sh1, sb_out_sh2,
        output busy, done, out_sh0, out_sh1, out_sh2, rnd_req, sb_in_sh0, sb_in_sh1, sb_in_sh2,
               sb_rnd
    );

    modport master (
        output start, in_sh0, in_sh1, in_sh2, rnd, rnd_valid, sb_out_sh0, sb_out_sh1, sb_out_sh2,
        input  busy, done, out_sh0, out_sh1, out_sh2, rnd_req, sb_in_sh0, sb_in_sh1, sb_in_sh2,
               sb_rnd
    );
endinterface

// File: rtl/prince_sbox_layer_ctrl.sv
// Sequences one 3-share masked PRINCE S-box over a 64-bit shared state, one nibble per cycle.
// Optional macro SB_LAYER_OUTMASK_EN: out_sh* read 0 until done, partial results kept internal.
module prince_sbox_layer_ctrl #(
    parameter int unsigned SB_LAT = 2,
    parameter int unsigned RND_W  = 54
) (
    input logic                     clk,
    input logic                     rst,
    prince_sbox_layer_ctrl_if.slave bus
);
    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [3:0]       issue_cnt_q, issue_cnt_d;
    logic [3:0]       cap_cnt_q;
    logic [63:0]      in0_q, in1_q, in2_q;
    logic [63:0]      res0_q, res1_q, res2_q;
    logic             pipe_vld_q [SB_LAT];
    logic [3:0]       pipe_idx_q [SB_LAT];
    logic             start_acc;
    logic             issue;
    logic             pop_vld;
    logic [3:0]       pop_idx;
    logic             last_cap;
    logic [RND_W-1:0] rnd_pass;

    assign start_acc = (state_q == StIdle) && bus.start;
    assign issue     = (state_q == StIssue) && bus.rnd_valid;
    assign pop_vld   = pipe_vld_q[SB_LAT-1];
    assign pop_idx   = pipe_idx_q[SB_LAT-1];
    assign last_cap  = pop_vld && (cap_cnt_q == 4'd15);

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) state_d = StIssue;
            end
            StIssue: begin
                if (bus.rnd_valid) begin
                    // 15 -> 0 wrap coincides with the move to DRAIN
                    issue_cnt_d = issue_cnt_q + 4'd1;
                    if (issue_cnt_q == 4'd15) state_d = StDrain;
                end
            end
            StDrain: begin
                if (last_cap) state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            issue_cnt_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in0_q <= '0;
            in1_q <= '0;
            in2_q <= '0;
        end else if (start_acc) begin
            in0_q <= bus.in_sh0;
            in1_q <= bus.in_sh1;
            in2_q <= bus.in_sh2;
        end
    end

    // Tracks which nibble each S-box pipeline slot holds; bubbles travel as valid=0
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < SB_LAT; i++) begin
                pipe_vld_q[i] <= 1'b0;
                pipe_idx_q[i] <= 4'd0;
            end
        end else begin
            pipe_vld_q[0] <= issue;
            pipe_idx_q[0] <= issue_cnt_q;
            for (int unsigned i = 1; i < SB_LAT; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_idx_q[i] <= pipe_idx_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            cap_cnt_q <= 4'd0;
            res0_q    <= '0;
            res1_q    <= '0;
            res2_q    <= '0;
        end else if (pop_vld) begin
            cap_cnt_q                       <= cap_cnt_q + 4'd1;
            res0_q[{pop_idx, 2'b00} +: 4] <= bus.sb_out_sh0;
            res1_q[{pop_idx, 2'b00} +: 4] <= bus.sb_out_sh1;
            res2_q[{pop_idx, 2'b00} +: 4] <= bus.sb_out_sh2;
        end
    end

    assign bus.busy      = (state_q == StIssue) || (state_q == StDrain);
    assign bus.done      = (state_q == StDone);
    assign bus.rnd_req   = issue;
    assign bus.sb_in_sh0 = issue ? in0_q[{issue_cnt_q, 2'b00} +: 4] : 4'd0;
    assign bus.sb_in_sh1 = issue ? in1_q[{issue_cnt_q, 2'b00} +: 4] : 4'd0;
    assign bus.sb_in_sh2 = issue ? in2_q[{issue_cnt_q, 2'b00} +: 4] : 4'd0;
    assign rnd_pass      = bus.rnd;
    assign bus.sb_rnd    = rnd_pass;

`ifdef SB_LAYER_OUTMASK_EN
    logic show_q;

    // Results become visible with done and stay until the next accepted start
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            show_q <= 1'b0;
        end else if (last_cap) begin
            show_q <= 1'b1;
        end
    end

    assign bus.out_sh0 = show_q ? res0_q : '0;
    assign bus.out_sh1 = show_q ? res1_q : '0;
    assign bus.out_sh2 = show_q ? res2_q : '0;
`else
    assign bus.out_sh0 = res0_q;
    assign bus.out_sh1 = res1_q;
    assign bus.out_sh2 = res2_q;
`endif
endmodule

// File: tb/tb_prince_sbox_layer_ctrl.sv
// Directed bench for prince_sbox_layer_ctrl with a pipelined 3-share S-box stand-in.
module tb_prince_sbox_layer_ctrl;
    localparam int unsigned SB_LAT = 2;
    localparam int unsigned RND_W  = 54;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    prince_sbox_layer_ctrl_if #(.RND_W(RND_W)) bus ();

    prince_sbox_layer_ctrl #(.SB_LAT(SB_LAT), .RND_W(RND_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // PRINCE S-box, S(i) at nibble i
    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [63:0] t;
        t = 64'h4D5E087619CA23FB;
        return t[{x, 2'b00} +: 4];
    endfunction

    // S-box stand-in: SB_LAT register stages, output shares remasked with sb_rnd
    logic [3:0] m0 [SB_LAT];
    logic [3:0] m1 [SB_LAT];
    logic [3:0] m2 [SB_LAT];
    always_ff @(posedge clk) begin
        m0[0] <= sbox(bus.sb_in_sh0 ^ bus.sb_in_sh1 ^ bus.sb_in_sh2) ^ bus.sb_rnd[3:0]
                 ^ bus.sb_rnd[7:4];
        m1[0] <= bus.sb_rnd[3:0];
        m2[0] <= bus.sb_rnd[7:4];
        for (int i = 1; i < SB_LAT; i++) begin
            m0[i] <= m0[i-1];
            m1[i] <= m1[i-1];
            m2[i] <= m2[i-1];
        end
    end
    assign bus.sb_out_sh0 = m0[SB_LAT-1];
    assign bus.sb_out_sh1 = m1[SB_LAT-1];
    assign bus.sb_out_sh2 = m2[SB_LAT-1];

    typedef struct {
        logic [63:0] pt;
        bit          split;
        bit          rnd_rand;
        logic [63:0] stall;
        logic [63:0] restart;
        logic [63:0] exp_ct;
    } vec_t;

    vec_t        vecs [6];
    logic [63:0] o0_arr [6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic run_layer(input vec_t v, input string tag, output logic [63:0] o0);
        int          done_cyc;
        int          req_cnt;
        int          bad_req;
        int          busy_err;
        int          bub;
        int          leak;
        int          exp_done;
        logic [63:0] prev_xor;
        logic [63:0] r1;
        logic [63:0] r2;
        logic [63:0] r64;
        done_cyc = 0; req_cnt = 0; bad_req = 0; busy_err = 0; bub = 0; leak = 0;
        prev_xor = '0;
        exp_done = 17 + int'(SB_LAT) + $countones(v.stall);
        r1 = {$urandom, $urandom};
        r2 = {$urandom, $urandom};
        @(negedge clk);
        bus.in_sh0    = v.split ? r1 : 64'd0;
        bus.in_sh1    = v.split ? r2 : 64'd0;
        bus.in_sh2    = v.split ? (v.pt ^ r1 ^ r2) : v.pt;
        bus.start     = 1'b1;
        bus.rnd_valid = 1'b1;
        for (int c = 1; c < 64 && done_cyc == 0; c++) begin
            @(negedge clk);
            bus.start     = v.restart[c];
            bus.rnd_valid = ~v.stall[c];
            r64           = v.rnd_rand ? {$urandom, $urandom} : 64'd0;
            bus.rnd       = r64[RND_W-1:0];
            #1;
            if (bus.rnd_req) req_cnt++;
            else if (req_cnt < 16) bub++;
            if (bus.rnd_req && !bus.rnd_valid) bad_req++;
            if (bus.done) begin
                done_cyc = c;
            end else begin
                if (!bus.busy) busy_err++;
                if ((bus.out_sh0 | bus.out_sh1 | bus.out_sh2) != 64'd0) leak++;
                prev_xor = bus.out_sh0 ^ bus.out_sh1 ^ bus.out_sh2;
            end
        end
        o0 = bus.out_sh0;
        chk({tag, " done cycle"}, 64'(done_cyc), 64'(exp_done));
        chk({tag, " rnd_req count"}, 64'(req_cnt), 64'd16);
        chk({tag, " bubbles"}, 64'(bub), 64'($countones(v.stall)));
        chk({tag, " rnd_req without rnd_valid"}, 64'(bad_req), 64'd0);
        chk({tag, " busy low before done"}, 64'(busy_err), 64'd0);
        chk({tag, " result"}, bus.out_sh0 ^ bus.out_sh1 ^ bus.out_sh2, v.exp_ct);
`ifdef SB_LAYER_OUTMASK_EN
        chk({tag, " out_sh nonzero before done"}, 64'(leak), 64'd0);
`else
        chk({tag, " partial result before done"}, {4'd0, prev_xor[59:0]},
            {4'd0, v.exp_ct[59:0]});
`endif
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        chk({tag, " busy after done"}, 64'(bus.busy), 64'd0);
        chk({tag, " done after done"}, 64'(bus.done), 64'd0);
        chk({tag, " result held"}, bus.out_sh0 ^ bus.out_sh1 ^ bus.out_sh2, v.exp_ct);
    endtask

    initial begin
        logic [63:0] r64;
        logic [63:0] o0;
        vec_t        v;

        vecs[0] = '{64'h0123456789ABCDEF, 1'b0, 1'b0, 64'd0, 64'd0, 64'hBF32AC916780E5D4};
        vecs[1] = '{64'h0123456789ABCDEF, 1'b1, 1'b1, 64'd0, 64'd0, 64'hBF32AC916780E5D4};
        vecs[2] = '{64'h0123456789ABCDEF, 1'b0, 1'b0, 64'h418, 64'd0, 64'hBF32AC916780E5D4};
        vecs[3] = '{64'hFEDCBA9876543210, 1'b1, 1'b1, 64'd0,
                    (64'd1 << 5) | (64'd1 << (17 + SB_LAT)), 64'h4D5E087619CA23FB};
        vecs[4] = '{64'h0000000000000000, 1'b1, 1'b1, 64'd0, 64'd0, 64'hBBBBBBBBBBBBBBBB};
        vecs[5] = '{64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b1, (64'd1 << 1) | (64'd1 << 16), 64'd0,
                    64'h4444444444444444};

        bus.start     = 1'b0;
        bus.in_sh0    = '0;
        bus.in_sh1    = '0;
        bus.in_sh2    = '0;
        bus.rnd_valid = 1'b1;
        r64           = {$urandom, $urandom};
        bus.rnd       = r64[RND_W-1:0];

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset done", 64'(bus.done), 64'd0);
        chk("reset rnd_req", 64'(bus.rnd_req), 64'd0);
        chk("reset out_sh0", bus.out_sh0, 64'd0);
        chk("reset out_sh1", bus.out_sh1, 64'd0);
        chk("reset out_sh2", bus.out_sh2, 64'd0);
        chk("reset sb_in", 64'({bus.sb_in_sh0, bus.sb_in_sh1, bus.sb_in_sh2}), 64'd0);
        chk("sb_rnd pass-through", 64'(bus.sb_rnd), 64'(r64[RND_W-1:0]));

        for (int i = 0; i < 6; i++) begin
            run_layer(vecs[i], $sformatf("vec%0d", i), o0);
            o0_arr[i] = o0;
        end
        n_tests++;
        if (o0_arr[1] == o0_arr[0]) begin
            n_fail++;
            $display("FAIL remasked out_sh0: got %h, required to differ from %h", o0_arr[1],
                     o0_arr[0]);
        end

        // Abort while nibble 8 is being issued
        @(negedge clk);
        bus.in_sh0    = 64'd0;
        bus.in_sh1    = 64'd0;
        bus.in_sh2    = 64'hFEDCBA9876543210;
        bus.start     = 1'b1;
        bus.rnd_valid = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        #1;
        chk("nibble 8 issued", 64'(bus.sb_in_sh2), 64'h8);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort busy", 64'(bus.busy), 64'd0);
        chk("abort rnd_req", 64'(bus.rnd_req), 64'd0);
        chk("abort out_sh", bus.out_sh0 | bus.out_sh1 | bus.out_sh2, 64'd0);
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("abort no done", 64'(bus.done), 64'd0);
            chk("abort out_sh stays 0", bus.out_sh0 | bus.out_sh1 | bus.out_sh2, 64'd0);
        end
        v = '{64'h0123456789ABCDEF, 1'b1, 1'b1, 64'd0, 64'd0, 64'hBF32AC916780E5D4};
        run_layer(v, "after abort", o0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
